// File: rtl/zig_sampler.sv
// zig_sampler: ziggurat rectangle-test stage (fast-accept compare, scale, sign).
// Define ZIG_SLOWPATH_EN to expose the slow_* rejected-candidate port; otherwise rejects are dropped.
`ifndef N
`define N 128
`endif
`ifndef LOG2N
`define LOG2N 7
`endif

module zig_sampler #(
  parameter int N     = `N,
  parameter int LOG2N = `LOG2N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              u_valid,
  output logic              u_ready,
  input  logic [LOG2N+32:0] u_data,
  output logic [LOG2N-1:0]  rect_idx,
  input  logic [17:0]       rmost_coord,
  input  logic [31:0]       wedge_bound_ratio,
  output logic              z_valid,
  input  logic              z_ready,
  output logic [18:0]       z_data,
`ifdef ZIG_SLOWPATH_EN
  output logic              slow_valid,
  input  logic              slow_ready,
  output logic [LOG2N-1:0]  slow_idx,
  output logic [31:0]       slow_frac,
  output logic              slow_sign,
`endif
  output logic [31:0]       acc_cnt,
  output logic [31:0]       rej_cnt
);

  if (N < 1 || N > (1 << LOG2N)) begin : g_cfg_check
    $error("zig_sampler: N must lie in 1..2**LOG2N");
  end

  // Q0.32 fraction times Q3.15 coordinate, truncated back to Q3.15.
  function automatic logic [17:0] scale_mag(input logic [31:0] frac, input logic [17:0] coord);
    return 18'(({18'd0, frac} * {32'd0, coord}) >> 32);
  endfunction

  function automatic logic [18:0] apply_sign(input logic [17:0] mag, input logic neg);
    logic [18:0] ext;
    ext = {1'b0, mag};
    if (neg) begin
      return 19'd0 - ext;
    end else begin
      return ext;
    end
  endfunction

  logic              s1_valid_r;
  logic [LOG2N-1:0]  s1_idx_r;
  logic [31:0]       s1_frac_r;
  logic              s1_sign_r;
  logic              z_valid_r;
  logic [18:0]       z_data_r;
  logic [31:0]       acc_cnt_r;
  logic [31:0]       rej_cnt_r;

  logic              fire_s;
  logic              u_ready_s;
  logic              s1_accept_s;
  logic              s1_advance_s;
  logic              acc_adv_s;
  logic              rej_adv_s;
  logic [LOG2N-1:0]  u_idx_s;
  logic [18:0]       z_next_s;

`ifdef ZIG_SLOWPATH_EN
  logic              slow_valid_r;
  logic [LOG2N-1:0]  slow_idx_r;
  logic [31:0]       slow_frac_r;
  logic              slow_sign_r;
`endif

  assign u_idx_s     = u_data[LOG2N+32:33];
  assign s1_accept_s = (s1_frac_r < wedge_bound_ratio);
  assign z_next_s    = apply_sign(scale_mag(s1_frac_r, rmost_coord), s1_sign_r);

  // Decide whether the candidate held in S1 leaves this cycle.
  always_comb begin
    s1_advance_s = 1'b0;
    if (!s1_valid_r) begin
      s1_advance_s = 1'b0;
    end else if (s1_accept_s) begin
      s1_advance_s = !z_valid_r || z_ready;
    end else begin
`ifdef ZIG_SLOWPATH_EN
      s1_advance_s = !slow_valid_r || slow_ready;
`else
      s1_advance_s = 1'b1;
`endif
    end
  end

  assign acc_adv_s = s1_valid_r && s1_accept_s && s1_advance_s;
  assign rej_adv_s = s1_valid_r && !s1_accept_s && s1_advance_s;
  assign u_ready_s = !s1_valid_r || s1_advance_s;
  assign fire_s    = u_valid && u_ready_s;

  // Hold the S1 index on the LUT address while not firing, so LUT data stays aligned through stalls.
  assign rect_idx = fire_s ? u_idx_s : s1_idx_r;
  assign u_ready  = u_ready_s;

  // S1 candidate register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_idx_r   <= {LOG2N{1'b0}};
      s1_frac_r  <= 32'd0;
      s1_sign_r  <= 1'b0;
    end else if (fire_s) begin
      s1_valid_r <= 1'b1;
      s1_idx_r   <= u_idx_s;
      s1_frac_r  <= u_data[31:0];
      s1_sign_r  <= u_data[32];
    end else if (s1_advance_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Sample output register; a same-cycle accept reloads it and keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_valid_r <= 1'b0;
      z_data_r  <= 19'd0;
    end else if (acc_adv_s) begin
      z_valid_r <= 1'b1;
      z_data_r  <= z_next_s;
    end else if (z_ready) begin
      z_valid_r <= 1'b0;
    end
  end

  // Accept / reject event counters, free-running with natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_r <= 32'd0;
      rej_cnt_r <= 32'd0;
    end else begin
      if (acc_adv_s) begin
        acc_cnt_r <= acc_cnt_r + 32'd1;
      end
      if (rej_adv_s) begin
        rej_cnt_r <= rej_cnt_r + 32'd1;
      end
    end
  end

`ifdef ZIG_SLOWPATH_EN
  // Rejected-candidate output register for the wedge/tail unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slow_valid_r <= 1'b0;
      slow_idx_r   <= {LOG2N{1'b0}};
      slow_frac_r  <= 32'd0;
      slow_sign_r  <= 1'b0;
    end else if (rej_adv_s) begin
      slow_valid_r <= 1'b1;
      slow_idx_r   <= s1_idx_r;
      slow_frac_r  <= s1_frac_r;
      slow_sign_r  <= s1_sign_r;
    end else if (slow_ready) begin
      slow_valid_r <= 1'b0;
    end
  end

  assign slow_valid = slow_valid_r;
  assign slow_idx   = slow_idx_r;
  assign slow_frac  = slow_frac_r;
  assign slow_sign  = slow_sign_r;
`endif

  assign z_valid = z_valid_r;
  assign z_data  = z_data_r;
  assign acc_cnt = acc_cnt_r;
  assign rej_cnt = rej_cnt_r;

endmodule

// File: tb/tb_zig_sampler.sv
// Scoreboard bench for zig_sampler: randomized words against an arithmetic reference model,
// plus directed latency, stall, boundary, reset and counter-wrap scenarios.
module tb_zig_sampler;
  localparam int N     = 128;
  localparam int LOG2N = 7;

  logic              clk;
  logic              rst_n;
  logic              u_valid;
  logic              u_ready;
  logic [LOG2N+32:0] u_data;
  logic [LOG2N-1:0]  rect_idx;
  logic [17:0]       rmost_coord;
  logic [31:0]       wedge_bound_ratio;
  logic              z_valid;
  logic              z_ready;
  logic [18:0]       z_data;
  logic [31:0]       acc_cnt;
  logic [31:0]       rej_cnt;
`ifdef ZIG_SLOWPATH_EN
  logic              slow_valid;
  logic              slow_ready;
  logic [LOG2N-1:0]  slow_idx;
  logic [31:0]       slow_frac;
  logic              slow_sign;
  logic [LOG2N+32:0] slow_q [$];
`endif

  logic [17:0] tb_coord [N];
  logic [31:0] tb_ratio [N];
  logic [18:0] z_q [$];
  int n_cmp = 0;
  int n_fail = 0;
  int n_pop = 0;
  int m_acc = 0;
  int m_rej = 0;
  int zr_mode = 0;
  logic [18:0]      snap_z;
  logic [LOG2N-1:0] snap_idx;

  zig_sampler #(.N(N), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst_n(rst_n),
    .u_valid(u_valid), .u_ready(u_ready), .u_data(u_data),
    .rect_idx(rect_idx), .rmost_coord(rmost_coord), .wedge_bound_ratio(wedge_bound_ratio),
    .z_valid(z_valid), .z_ready(z_ready), .z_data(z_data),
`ifdef ZIG_SLOWPATH_EN
    .slow_valid(slow_valid), .slow_ready(slow_ready), .slow_idx(slow_idx),
    .slow_frac(slow_frac), .slow_sign(slow_sign),
`endif
    .acc_cnt(acc_cnt), .rej_cnt(rej_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LUT model: one-cycle registered read of the tables.
  always @(posedge clk) begin
    rmost_coord       <= tb_coord[rect_idx];
    wedge_bound_ratio <= tb_ratio[rect_idx];
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: x = f * coord in real terms, truncated to Q3.15, then negated for sign.
  function automatic logic [18:0] model_z(input logic [31:0] f, input logic [17:0] c, input logic s);
    longint unsigned p;
    int mag;
    int v;
    p   = longint'(f) * longint'(c);
    mag = int'(p >> 32);
    v   = s ? -mag : mag;
    return v[18:0];
  endfunction

  // Called at (or shortly after) a falling edge; returns at the falling edge after the fire edge.
  task automatic send(input int idx, input logic [31:0] f, input logic s);
    int guard;
    logic [LOG2N-1:0] ix;
    ix = idx[LOG2N-1:0];
    u_data  = {ix, s, f};
    u_valid = 1'b1;
    guard   = 0;
    #1;
    while (!u_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!u_ready) begin
      check("u_ready_timeout", {63'd0, u_ready}, 64'd1);
    end else if (f < tb_ratio[ix]) begin
      z_q.push_back(model_z(f, tb_coord[ix], s));
      m_acc++;
    end else begin
      m_rej++;
`ifdef ZIG_SLOWPATH_EN
      slow_q.push_back({ix, s, f});
`endif
    end
    @(negedge clk);
    u_valid = 1'b0;
  endtask

  function automatic logic busy();
`ifdef ZIG_SLOWPATH_EN
    return (z_q.size() != 0) || z_valid || (slow_q.size() != 0) || slow_valid;
`else
    return (z_q.size() != 0) || z_valid;
`endif
  endfunction

  task automatic drain();
    int guard;
    guard   = 0;
    zr_mode = 0;
    z_ready = 1'b1;
`ifdef ZIG_SLOWPATH_EN
    slow_ready = 1'b1;
`endif
    while (busy() && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
    check("drain_z_queue_empty", 64'(z_q.size()), 64'd0);
`ifdef ZIG_SLOWPATH_EN
    check("drain_slow_queue_empty", 64'(slow_q.size()), 64'd0);
`endif
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_acc_cnt"}, {32'd0, acc_cnt}, 64'(m_acc));
    check({tag, "_rej_cnt"}, {32'd0, rej_cnt}, 64'(m_rej));
  endtask

  // Ready driver: 0 = always ready, 1 = random backpressure, 2 = main thread drives z_ready.
  initial begin
    forever begin
      @(negedge clk);
      if (zr_mode == 1) begin
        z_ready = ($urandom_range(0, 3) != 0);
`ifdef ZIG_SLOWPATH_EN
        slow_ready = ($urandom_range(0, 2) != 0);
`endif
      end else if (zr_mode == 0) begin
        z_ready = 1'b1;
`ifdef ZIG_SLOWPATH_EN
        slow_ready = 1'b1;
`endif
      end
    end
  end

  // Sample monitor: pops the scoreboard on each handshake and checks stall stability.
  initial begin : z_mon
    logic prev_stall;
    logic [18:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 19'd0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("z_hold_valid", {63'd0, z_valid}, 64'd1);
          check("z_hold_data", {45'd0, z_data}, {45'd0, prev_data});
        end
        if (z_valid && z_ready) begin
          if (z_q.size() == 0) check("z_spurious_sample", {45'd0, z_data}, 64'hDEAD);
          else check("z_data", {45'd0, z_data}, {45'd0, z_q.pop_front()});
          n_pop++;
        end
        prev_stall = z_valid && !z_ready;
        prev_data  = z_data;
      end
    end
  end

`ifdef ZIG_SLOWPATH_EN
  initial begin : slow_mon
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && slow_valid && slow_ready) begin
        if (slow_q.size() == 0) check("slow_spurious", {32'd0, slow_frac}, 64'hDEAD);
        else check("slow_data", 64'({slow_idx, slow_sign, slow_frac}), 64'(slow_q.pop_front()));
      end
    end
  end
`endif

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pop0;
    rst_n   = 1'b0;
    u_valid = 1'b0;
    u_data  = '0;
    z_ready = 1'b1;
`ifdef ZIG_SLOWPATH_EN
    slow_ready = 1'b1;
`endif
    for (int i = 0; i < N; i++) begin
      tb_coord[i] = 18'($urandom);
      tb_ratio[i] = $urandom;
    end
    for (int i = 0; i < 8; i++) tb_ratio[i] = 32'hFFFF_FFFF;
    tb_coord[20] = 18'h10000;  tb_ratio[20] = 32'h8000_0000;
    tb_coord[9]  = 18'h3FFFF;  tb_ratio[9]  = 32'hFFFF_FFFF;
    tb_ratio[10] = 32'h1234_5678;
    tb_ratio[11] = 32'h0000_0000;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("reset_u_ready", {63'd0, u_ready}, 64'd1);
    check("reset_z_valid", {63'd0, z_valid}, 64'd0);
    check("reset_z_data", {45'd0, z_data}, 64'd0);
    check("reset_rect_idx", 64'(rect_idx), 64'd0);
    check_counts("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Accept with negative sign, latency 2
    @(negedge clk);
    send(20, 32'h4000_0000, 1'b1);
    #2;
    check("lat_not_yet_valid", {63'd0, z_valid}, 64'd0);
    @(negedge clk);
    #2;
    check("neg_accept_valid", {63'd0, z_valid}, 64'd1);
    check("neg_accept_data", {45'd0, z_data}, 64'h7C000);
    drain();
    check_counts("neg_accept");

    // Reject: no sample appears
    @(negedge clk);
    send(20, 32'hC000_0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #2;
      check("reject_no_z_valid", {63'd0, z_valid}, 64'd0);
`ifdef ZIG_SLOWPATH_EN
      if (k == 1) begin
        check("reject_slow_valid", {63'd0, slow_valid}, 64'd1);
        check("reject_slow_frac", {32'd0, slow_frac}, 64'hC000_0000);
        check("reject_slow_idx", 64'(slow_idx), 64'd20);
      end
`endif
      @(negedge clk);
    end
    drain();
    check_counts("reject");

    // Boundaries: f=0 both signs, f=ratio, near-full ratio, ratio=0
    @(negedge clk);
    send(10, 32'd0, 1'b0);
    send(10, 32'd0, 1'b1);
    send(10, 32'h1234_5678, 1'b1);
    send(9, 32'hFFFF_FFFE, 1'b1);
    send(11, 32'd5, 1'b0);
    drain();
    check_counts("boundary");

    // Back-to-back accepts with z_ready low for cycles 3..6
    @(negedge clk);
    zr_mode = 2;
    z_ready = 1'b1;
    pop0    = n_pop;
    fork
      begin
        for (int i = 0; i < 8; i++) send(i, $urandom & 32'hFFFF_FFFE, 1'($urandom_range(0, 1)));
      end
      begin
        repeat (3) @(negedge clk);
        z_ready = 1'b0;
        @(negedge clk);
        #2;
        snap_z   = z_data;
        snap_idx = rect_idx;
        check("stall_z_valid", {63'd0, z_valid}, 64'd1);
        @(negedge clk);
        #2;
        check("stall_z_data_held", {45'd0, z_data}, {45'd0, snap_z});
        check("stall_rect_idx_held", 64'(rect_idx), 64'(snap_idx));
        check("stall_u_ready_low", {63'd0, u_ready}, 64'd0);
        repeat (2) @(negedge clk);
        z_ready = 1'b1;
      end
    join
    drain();
    check("stall_delivered_count", 64'(n_pop - pop0), 64'd8);
    check_counts("stall");

    // Randomized traffic with random backpressure
    zr_mode = 1;
    for (int i = 0; i < 300; i++) begin
      int idx;
      logic [31:0] f;
      idx = int'($urandom_range(0, N - 1));
      f   = ($urandom_range(0, 3) == 0) ? tb_ratio[idx] : $urandom;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(idx, f, 1'($urandom_range(0, 1)));
    end
    drain();
    check_counts("random");

    // Async reset mid-stream
    @(negedge clk);
    zr_mode = 2;
    z_ready = 1'b0;
    send(20, 32'h4000_0000, 1'b0);
    send(20, 32'h2000_0000, 1'b1);
    #1;
    check("pre_reset_z_valid", {63'd0, z_valid}, 64'd1);
    check("pre_reset_u_ready", {63'd0, u_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_z_valid", {63'd0, z_valid}, 64'd0);
    check("midrst_u_ready", {63'd0, u_ready}, 64'd1);
    check("midrst_z_data", {45'd0, z_data}, 64'd0);
    check("midrst_rect_idx", 64'(rect_idx), 64'd0);
    check("midrst_acc_cnt", {32'd0, acc_cnt}, 64'd0);
    check("midrst_rej_cnt", {32'd0, rej_cnt}, 64'd0);
`ifdef ZIG_SLOWPATH_EN
    check("midrst_slow_valid", {63'd0, slow_valid}, 64'd0);
    slow_q.delete();
`endif
    z_q.delete();
    m_acc = 0;
    m_rej = 0;
    @(negedge clk);
    rst_n   = 1'b1;
    zr_mode = 0;
    z_ready = 1'b1;
    @(negedge clk);
    send(20, 32'h4000_0000, 1'b0);
    #2;
    check("post_rst_lat_not_yet", {63'd0, z_valid}, 64'd0);
    @(negedge clk);
    #2;
    check("post_rst_valid", {63'd0, z_valid}, 64'd1);
    check("post_rst_data", {45'd0, z_data}, 64'h04000);
    drain();
    check_counts("post_reset");

    // Accept counter wrap
    @(negedge clk);
    force dut.acc_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.acc_cnt_r;
    #1;
    check("wrap_preload", {32'd0, acc_cnt}, 64'hFFFF_FFFF);
    send(20, 32'h1000_0000, 1'b0);
    @(negedge clk);
    #2;
    check("wrap_to_zero", {32'd0, acc_cnt}, 64'd0);
    check("wrap_rej_cnt", {32'd0, rej_cnt}, 64'(m_rej));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
